// File: rtl/fft8_input_framer_if.sv
// Handshake and frame bus between a sample producer/frame consumer and the FFT input framer.
// The master side drives samples and takes frames; the slave side is the framer.
interface fft8_input_framer_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_real;
  logic [DATA_W-1:0] s_imag;
  logic              s_last;
  logic              frame_valid;
  logic              frame_ready;
  logic [DATA_W-1:0] a_real0, a_real1, a_real2, a_real3;
  logic [DATA_W-1:0] a_real4, a_real5, a_real6, a_real7;
  logic [DATA_W-1:0] a_imag0, a_imag1, a_imag2, a_imag3;
  logic [DATA_W-1:0] a_imag4, a_imag5, a_imag6, a_imag7;
  logic              last_err;
  logic              clr_err;

  modport master (
    output s_valid, s_real, s_imag, s_last, frame_ready, clr_err,
    input  s_ready, frame_valid, last_err,
    input  a_real0, a_real1, a_real2, a_real3, a_real4, a_real5, a_real6, a_real7,
    input  a_imag0, a_imag1, a_imag2, a_imag3, a_imag4, a_imag5, a_imag6, a_imag7
  );

  modport slave (
    input  s_valid, s_real, s_imag, s_last, frame_ready, clr_err,
    output s_ready, frame_valid, last_err,
    output a_real0, a_real1, a_real2, a_real3, a_real4, a_real5, a_real6, a_real7,
    output a_imag0, a_imag1, a_imag2, a_imag3, a_imag4, a_imag5, a_imag6, a_imag7
  );
endinterface

// File: rtl/fft8_input_framer.sv
// Ping-pong framer: gathers 8 serial complex samples per bank and presents each
// finished frame in parallel to the 8-point FFT core while the other bank fills.
module fft8_input_framer #(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  fft8_input_framer_if.slave bus
);

  logic [DATA_W-1:0] r_bankRe [2][8];
  logic [DATA_W-1:0] r_bankIm [2][8];
  logic              r_wrSel;
  logic              r_rdSel;
  logic [2:0]        r_wrCnt;
  logic [1:0]        r_full;
  logic              r_lastErr;

  logic       w_accept;
  logic       w_take;
  logic       w_frameEnd;
  logic       w_lastBad;
  logic [1:0] w_setMask;
  logic [1:0] w_clrMask;

  assign bus.s_ready     = !r_full[r_wrSel];
  assign bus.frame_valid = r_full[r_rdSel];
  assign bus.last_err    = r_lastErr;

  assign w_accept   = bus.s_valid & !r_full[r_wrSel];
  assign w_take     = r_full[r_rdSel] & bus.frame_ready;
  assign w_frameEnd = (r_wrCnt == 3'd7);
  assign w_lastBad  = bus.s_last ^ w_frameEnd;

  // Accept only ever targets an empty bank and take only a full one, so the
  // set and clear masks never hit the same bit and may land in the same edge.
  assign w_setMask = (w_accept && w_frameEnd) ? (2'b01 << r_wrSel) : 2'b00;
  assign w_clrMask = w_take ? (2'b01 << r_rdSel) : 2'b00;

  // Sample storage carries no reset; the full flags alone say what is valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bankRe[r_wrSel][r_wrCnt] <= bus.s_real;
      r_bankIm[r_wrSel][r_wrCnt] <= bus.s_imag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrSel   <= 1'b0;
      r_rdSel   <= 1'b0;
      r_wrCnt   <= 3'd0;
      r_full    <= 2'b00;
      r_lastErr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wrCnt <= r_wrCnt + 3'd1;
        if (w_frameEnd) begin
          r_wrSel <= !r_wrSel;
        end
      end
      if (w_take) begin
        r_rdSel <= !r_rdSel;
      end
      r_full <= (r_full | w_setMask) & ~w_clrMask;
      // A fresh framing error outranks a simultaneous clear.
      if (w_accept && w_lastBad) begin
        r_lastErr <= 1'b1;
      end else if (bus.clr_err) begin
        r_lastErr <= 1'b0;
      end
    end
  end

  assign bus.a_real0 = r_bankRe[r_rdSel][0];
  assign bus.a_real1 = r_bankRe[r_rdSel][1];
  assign bus.a_real2 = r_bankRe[r_rdSel][2];
  assign bus.a_real3 = r_bankRe[r_rdSel][3];
  assign bus.a_real4 = r_bankRe[r_rdSel][4];
  assign bus.a_real5 = r_bankRe[r_rdSel][5];
  assign bus.a_real6 = r_bankRe[r_rdSel][6];
  assign bus.a_real7 = r_bankRe[r_rdSel][7];
  assign bus.a_imag0 = r_bankIm[r_rdSel][0];
  assign bus.a_imag1 = r_bankIm[r_rdSel][1];
  assign bus.a_imag2 = r_bankIm[r_rdSel][2];
  assign bus.a_imag3 = r_bankIm[r_rdSel][3];
  assign bus.a_imag4 = r_bankIm[r_rdSel][4];
  assign bus.a_imag5 = r_bankIm[r_rdSel][5];
  assign bus.a_imag6 = r_bankIm[r_rdSel][6];
  assign bus.a_imag7 = r_bankIm[r_rdSel][7];

endmodule

// File: tb/tb_fft8_input_framer.sv
// Directed bench for fft8_input_framer: fill, backpressure, streaming, framing
// errors, simultaneous fill/take and asynchronous reset, all with fixed expectations.
module tb_fft8_input_framer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fft8_input_framer_if #(.DATA_W(32)) bus ();

  fft8_input_framer #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] obsRe [8];
  logic [31:0] obsIm [8];
  assign obsRe[0] = bus.a_real0;
  assign obsRe[1] = bus.a_real1;
  assign obsRe[2] = bus.a_real2;
  assign obsRe[3] = bus.a_real3;
  assign obsRe[4] = bus.a_real4;
  assign obsRe[5] = bus.a_real5;
  assign obsRe[6] = bus.a_real6;
  assign obsRe[7] = bus.a_real7;
  assign obsIm[0] = bus.a_imag0;
  assign obsIm[1] = bus.a_imag1;
  assign obsIm[2] = bus.a_imag2;
  assign obsIm[3] = bus.a_imag3;
  assign obsIm[4] = bus.a_imag4;
  assign obsIm[5] = bus.a_imag5;
  assign obsIm[6] = bus.a_imag6;
  assign obsIm[7] = bus.a_imag7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] re, input logic [31:0] im,
                               input logic last);
    bus.s_valid = v;
    bus.s_real  = re;
    bus.s_imag  = im;
    bus.s_last  = last;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int accCnt;
    int lowCnt;
    int frameCnt;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.frame_ready = 1'b0;
    bus.clr_err     = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    checkOutput("rst_last_err", 32'(bus.last_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single frame with consumer ready
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) checkOutput("t1_not_valid_at7", 32'(bus.frame_valid), 32'd0);
      applyStimulus(1'b1, 32'h0 + k, 32'h100 + k, k == 7);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("t1_frame_valid", 32'(bus.frame_valid), 32'd1);
    checkOutput("t1_a_real3", bus.a_real3, 32'h3);
    checkOutput("t1_a_imag7", bus.a_imag7, 32'h107);
    checkOutput("t1_last_err", 32'(bus.last_err), 32'd0);
    checkOutput("t1_s_ready", 32'(bus.s_ready), 32'd1);
    tick();
    checkOutput("t1_taken", 32'(bus.frame_valid), 32'd0);

    // Backpressure: 24 offered, only two banks' worth accepted
    bus.frame_ready = 1'b0;
    accCnt = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 32'h200 + i, 32'h300 + i, (i % 8) == 7);
      if (bus.s_ready) accCnt++;
      tick();
      if (i == 12) checkOutput("t2_a_held_mid", bus.a_real0, 32'h200);
      if (i == 15) checkOutput("t2_ready_low_after16", 32'(bus.s_ready), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("t2_accepted", accCnt, 32'd16);
    checkOutput("t2_s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("t2_frame_valid", 32'(bus.frame_valid), 32'd1);
    checkOutput("t2_a_real0", bus.a_real0, 32'h200);
    checkOutput("t2_a_imag7", bus.a_imag7, 32'h307);
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    checkOutput("t2_b_valid", 32'(bus.frame_valid), 32'd1);
    checkOutput("t2_b_a_real0", bus.a_real0, 32'h208);
    checkOutput("t2_b_a_imag3", bus.a_imag3, 32'h30b);
    checkOutput("t2_ready_rises", 32'(bus.s_ready), 32'd1);
    bus.frame_ready = 1'b1;
    tick();
    checkOutput("t2_b_taken", 32'(bus.frame_valid), 32'd0);

    // Continuous streaming of 64 samples
    lowCnt = 0;
    frameCnt = 0;
    for (int i = 0; i <= 64; i++) begin
      if (!bus.s_ready) lowCnt++;
      if (bus.frame_valid) begin
        for (int k = 0; k < 8; k++) begin
          checkOutput($sformatf("t3_re_f%0d_k%0d", frameCnt, k), obsRe[k], 32'h1000 + 8 * frameCnt + k);
          checkOutput($sformatf("t3_im_f%0d_k%0d", frameCnt, k), obsIm[k], 32'h2000 + 8 * frameCnt + k);
        end
        frameCnt++;
      end
      if (i < 64) applyStimulus(1'b1, 32'h1000 + i, 32'h2000 + i, (i % 8) == 7);
      else        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
      tick();
    end
    checkOutput("t3_ready_low_cycles", lowCnt, 32'd0);
    checkOutput("t3_frames", frameCnt, 32'd8);
    checkOutput("t3_drained", 32'(bus.frame_valid), 32'd0);
    checkOutput("t3_last_err", 32'(bus.last_err), 32'd0);

    // Misplaced s_last: flag is sticky, framing follows the count
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 32'h400 + k, 32'h480 + k, k == 4);
      tick();
      if (k == 4) checkOutput("t4_err_set", 32'(bus.last_err), 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("t4_frame_closes", 32'(bus.frame_valid), 32'd1);
    checkOutput("t4_a_real4", bus.a_real4, 32'h404);
    checkOutput("t4_err_sticky", 32'(bus.last_err), 32'd1);
    tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    checkOutput("t4_err_cleared", 32'(bus.last_err), 32'd0);
    bus.clr_err = 1'b1;
    applyStimulus(1'b1, 32'h4a0, 32'h4b0, 1'b1);
    tick();
    bus.clr_err = 1'b0;
    checkOutput("t4_set_wins", 32'(bus.last_err), 32'd1);
    for (int k = 1; k < 8; k++) begin
      applyStimulus(1'b1, 32'h4a0 + k, 32'h4b0 + k, k == 7);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("t4_frame2_valid", 32'(bus.frame_valid), 32'd1);
    checkOutput("t4_frame2_a_real0", bus.a_real0, 32'h4a0);
    tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    checkOutput("t4_err_cleared2", 32'(bus.last_err), 32'd0);

    // 8th sample of B accepted in the same edge A is taken
    bus.frame_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 32'h500 + k, 32'h580 + k, k == 7);
      tick();
    end
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 32'h600 + k, 32'h680 + k, 1'b0);
      tick();
      if (k == 3) checkOutput("t5_a_held", bus.a_real0, 32'h500);
    end
    checkOutput("t5_a_valid", 32'(bus.frame_valid), 32'd1);
    checkOutput("t5_a_imag7", bus.a_imag7, 32'h587);
    applyStimulus(1'b1, 32'h607, 32'h687, 1'b1);
    bus.frame_ready = 1'b1;
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    bus.frame_ready = 1'b0;
    checkOutput("t5_valid_stays", 32'(bus.frame_valid), 32'd1);
    checkOutput("t5_b_a_real0", bus.a_real0, 32'h600);
    checkOutput("t5_b_a_imag7", bus.a_imag7, 32'h687);
    checkOutput("t5_s_ready", 32'(bus.s_ready), 32'd1);
    bus.frame_ready = 1'b1;
    tick();
    checkOutput("t5_b_taken", 32'(bus.frame_valid), 32'd0);

    // Asynchronous reset with one full frame and a partial one in flight
    bus.frame_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 32'h800 + k, 32'h880 + k, k == 0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 32'h900 + k, 32'h980 + k, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("t6_pre_valid", 32'(bus.frame_valid), 32'd1);
    checkOutput("t6_pre_err", 32'(bus.last_err), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_s_ready", 32'(bus.s_ready), 32'd1);
    checkOutput("t6_rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    checkOutput("t6_rst_last_err", 32'(bus.last_err), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 32'h700 + k, 32'h780 + k, k == 7);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("t6_clean_valid", 32'(bus.frame_valid), 32'd1);
    checkOutput("t6_clean_a_real0", bus.a_real0, 32'h700);
    checkOutput("t6_clean_a_real7", bus.a_real7, 32'h707);
    checkOutput("t6_clean_a_imag2", bus.a_imag2, 32'h782);
    checkOutput("t6_clean_last_err", 32'(bus.last_err), 32'd0);
    tick();
    checkOutput("t6_clean_taken", 32'(bus.frame_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
